// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler: loads a coefficient bank from ROM into the FIR's serial
// tap port and turns left-channel word-select strobes into FIR clock enables.
// Samples arriving while a load is in progress are dropped and counted.
module fir_tap_scheduler #(
  parameter int NTAPS  = 16,
  parameter int NBANKS = 4,
  parameter int BANK_W = 2,
  parameter int IDX_W  = 4,
  parameter int TAP_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_bank_req,
  input  logic [BANK_W-1:0]       i_bank_sel,
  input  logic                    i_wsp,
  input  logic                    i_ws,
  input  logic                    i_drop_clr,
  output logic [BANK_W+IDX_W-1:0] o_rom_addr,
  input  logic [TAP_W-1:0]        i_rom_data,
  output logic [TAP_W-1:0]        o_tap,
  output logic                    o_tap_wr,
  output logic                    o_ce,
  output logic                    o_busy,
  output logic                    o_load_done,
  output logic [BANK_W-1:0]       o_loaded_bank,
  output logic [7:0]              o_drop_cnt
);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    IDLE = 3'd1,
    LOAD = 3'd2,
    LAST = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NTAPS - 1);

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  idx;
  logic [BANK_W-1:0] bank;
  logic              sample_ev;
  logic              req_ok;

  // A left-channel sample is a word-select edge with WS low.
  assign sample_ev = i_wsp & ~i_ws;
  // Only banks the ROM actually holds can be requested.
  assign req_ok    = i_bank_req && (32'(i_bank_sel) < NBANKS);

  // ROM is addressed straight from the bank/index registers; the tap value
  // is the ROM word itself, the write strobe is delayed to match ROM latency.
  assign o_rom_addr = {bank, idx};
  assign o_tap      = i_rom_data;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= BOOT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic for the load sequencer.
  always_comb begin
    next_state = state;
    case (state)
      BOOT: next_state = LOAD;
      IDLE: begin
        if (req_ok) begin
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        if (idx == IDX_LAST) begin
          next_state = LAST;
        end else begin
          next_state = LOAD;
        end
      end
      LAST:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = BOOT;
    endcase
  end

  // Bank/index tracking and the registered strobes derived from the state.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      idx           <= '0;
      bank          <= '0;
      o_tap_wr      <= 1'b0;
      o_ce          <= 1'b0;
      o_load_done   <= 1'b0;
      o_loaded_bank <= '0;
      o_busy        <= 1'b1;
    end else begin
      case (state)
        BOOT:    bank <= '0;
        IDLE:    bank <= req_ok ? i_bank_sel : bank;
        default: bank <= bank;
      endcase
      if (state == LOAD) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        idx <= '0;
      end
      // ROM data for a LOAD address arrives one cycle later, so the write
      // strobe trails every LOAD cycle by one (covering LAST, not first LOAD).
      o_tap_wr    <= (state == LOAD);
      o_ce        <= sample_ev && (state == IDLE);
      o_load_done <= (state == LAST);
      if (state == LAST) begin
        o_loaded_bank <= bank;
      end
      o_busy <= (next_state != IDLE);
    end
  end

  // Saturating count of samples lost while busy; clear has priority.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_drop_cnt <= 8'd0;
    end else if (i_drop_clr) begin
      o_drop_cnt <= 8'd0;
    end else if (sample_ev && (state != IDLE) && (o_drop_cnt != 8'hFF)) begin
      o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

endmodule
